// File: rtl/rf_wb_pkg.sv
// -----------------------------------------------------------------------------
// rf_wb_pkg
// Shared definitions for the register-file writeback arbiter.
//   - gnt_e     : grant encoding (GNT_NONE / GNT_ALU / GNT_LSU)
//   - STALL_W   : width of the exported stall counter
// Optional feature macro used by the arbiter: RF_WB_STARVE_GUARD_EN.
// -----------------------------------------------------------------------------
package rf_wb_pkg;

    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } gnt_e;

endpackage : rf_wb_pkg

// File: rtl/rf_wb_starve_ctr.sv
// -----------------------------------------------------------------------------
// rf_wb_starve_ctr
// Counts consecutive cycles in which the ALU requested but was not granted.
// When the count reaches STARVE_MAX the force flag is raised, letting the ALU
// win over the LSU for one cycle. Only instantiated when RF_WB_STARVE_GUARD_EN
// is defined.
// Ports:
//   clk        in  : clock
//   rst        in  : synchronous active-high reset
//   alu_valid  in  : ALU request
//   alu_ready  in  : ALU grant this cycle
//   force_alu  out : ALU must win this cycle (from registered count only)
// -----------------------------------------------------------------------------
module rf_wb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic alu_valid,
    input  logic alu_ready,
    output logic force_alu
);
    import rf_wb_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    // Force depends only on the registered count, so there is no
    // combinational path back from alu_ready.
    assign force_alu = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (!alu_valid || alu_ready) begin
            // An ALU transfer (including the forced one) or an idle ALU
            // ends the losing streak.
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule : rf_wb_starve_ctr

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between the ALU writeback path
// and the LSU load-return path. LSU has fixed priority; one write per cycle.
// Writes to x0 are accepted but dropped (rf_we stays 0 for that slot).
// Outputs to the register file are registered (1-cycle accept-to-write).
// Optional starvation guard: define RF_WB_STARVE_GUARD_EN to let the ALU win
// after STARVE_MAX consecutive losses.
// Ports:
//   r_clk, r_rst                  : clock, synchronous active-high reset
//   alu_valid/addr/data, alu_ready: ALU writeback handshake
//   lsu_valid/addr/data, lsu_ready: LSU writeback handshake
//   rf_we, rf_addr_rd, rf_data_rd : registered register-file write port
//   stall_cnt                     : saturating count of stalled cycles
// Handshake: a transfer happens when valid && ready; ready is combinational
// from the valids and internal state only, never from addr/data, and a
// requester holds valid/addr/data until it sees ready.
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              alu_valid,
    input  logic [AWIDTH-1:0] alu_addr,
    input  logic [DWIDTH-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [AWIDTH-1:0] lsu_addr,
    input  logic [DWIDTH-1:0] lsu_data,
    output logic              lsu_ready,
    output logic              rf_we,
    output logic [AWIDTH-1:0] rf_addr_rd,
    output logic [DWIDTH-1:0] rf_data_rd,
    output logic [15:0]       stall_cnt
);
    import rf_wb_pkg::*;

    gnt_e               gnt;
    logic               force_alu;
    logic               stalled;

    logic               rf_we_q,   rf_we_d;
    logic [AWIDTH-1:0]  rf_addr_q, rf_addr_d;
    logic [DWIDTH-1:0]  rf_data_q, rf_data_d;
    logic [STALL_W-1:0] stall_q,   stall_d;

`ifdef RF_WB_STARVE_GUARD_EN
    rf_wb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk       (r_clk),
        .rst       (r_rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .force_alu (force_alu)
    );
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
    assign force_alu         = 1'b0;
`endif

    // Grant: LSU over ALU unless the guard forces an ALU win. Nothing is
    // granted while reset is asserted.
    always_comb begin
        gnt = GNT_NONE;
        if (!r_rst) begin
            if (alu_valid && force_alu) begin
                gnt = GNT_ALU;
            end else if (lsu_valid) begin
                gnt = GNT_LSU;
            end else if (alu_valid) begin
                gnt = GNT_ALU;
            end
        end
    end

    assign alu_ready = (gnt == GNT_ALU);
    assign lsu_ready = (gnt == GNT_LSU);
    assign stalled   = (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready);

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        case (gnt)
            GNT_ALU: begin
                rf_we_d   = (alu_addr != '0);
                rf_addr_d = alu_addr;
                rf_data_d = alu_data;
            end
            GNT_LSU: begin
                rf_we_d   = (lsu_addr != '0);
                rf_addr_d = lsu_addr;
                rf_data_d = lsu_data;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase

        stall_d = stall_q;
        if (stalled && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            stall_q   <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            stall_q   <= stall_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_addr_rd = rf_addr_q;
    assign rf_data_rd = rf_data_q;
    assign stall_cnt  = stall_q;

endmodule : rf_wb_arbiter
